// File: rtl/fft_pkg.sv
// Shared FFT constants, sample type and index bit reversal, used by the
// input feeder and the output reorder block.
`timescale 1ns/1ps
package fft_pkg;
  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int SAMPLE_W  = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Reverses the low `bits` bits of i; callers truncate to their address width.
  function automatic int unsigned bit_rev(input int unsigned i, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < bits; k++) begin
      r = (r << 1) | ((i >> k) & 1);
    end
    return r;
  endfunction
endpackage

// File: rtl/pingpong_ram.sv
// Two N-deep sample banks: one synchronous write port, one combinational read port.
`timescale 1ns/1ps
module pingpong_ram #(
  parameter int N     = 64,
  parameter int LOG2N = 6,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_bank,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  // Bank select is the top address bit; contents are deliberately not reset.
  logic [W-1:0] mem [0:2*N-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/bitrev_feeder.sv
// Natural-order to bit-reversed-order frame reorder ahead of the DIT FFT:
// scatter on write into a ping-pong bank, sequential read into an output register.
`timescale 1ns/1ps
module bitrev_feeder
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int W     = SAMPLE_W
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_first,
  output logic         out_last
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic             wr_bank, rd_bank;
  logic [LOG2N-1:0] wcnt, rcnt;
  logic [1:0]       full;
  logic             wr_fire, load;
  logic [LOG2N-1:0] wr_addr;
  logic [W-1:0]     rd_data;

  // Write side needs an empty bank, read side a full one, so they never collide.
  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign load     = full[rd_bank] && (!out_valid || out_ready);
  assign wr_addr  = LOG2N'(bit_rev(int'(wcnt), LOG2N));

  pingpong_ram #(.N(N), .LOG2N(LOG2N), .W(W)) u_ram (
    .clk     (clk),
    .we      (wr_fire),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_bank (rd_bank),
    .rd_addr (rcnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      // Setting one bank's full bit and clearing the other's on one edge is
      // what gives seamless streaming across frame boundaries.
      if (load) begin
        out_data  <= rd_data;
        out_first <= (rcnt == '0);
        out_last  <= (rcnt == LAST);
        out_valid <= 1'b1;
        rcnt      <= rcnt + 1'b1;
        if (rcnt == LAST) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_feeder.sv
// Scoreboard bench for bitrev_feeder: accepted inputs are grouped into frames,
// each frame is permuted by a reference bit reversal, and a monitor checks outputs.
`timescale 1ns/1ps
module tb_bitrev_feeder;
  localparam int N     = 64;
  localparam int LOG2N = 6;

  logic        clk = 0;
  logic        nrst = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_data;
  logic        out_first, out_last;

  bitrev_feeder dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        f;
    logic        l;
  } item_t;

  logic [31:0] in_q[$];
  item_t       exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int n_first  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference reversal by repeated halving, independent of the RTL helper.
  function automatic int ref_rev(input int i);
    int r, v;
    r = 0;
    v = i;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Monitor: sampled mid-cycle, so these handshakes complete on the next rising edge.
  always @(negedge clk) begin
    if (!nrst) begin
      in_q.delete();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        in_q.push_back(in_data);
        if (in_q.size() == N) begin
          for (int p = 0; p < N; p++) begin
            item_t it;
            it.d = in_q[ref_rev(p)];
            it.f = (p == 0);
            it.l = (p == N - 1);
            exp_q.push_back(it);
          end
          in_q.delete();
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (out_first) n_first++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_first_last", {62'd0, out_first, out_last}, {62'd0, e.f, e.l});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 0;
    in_valid = 0;
    tick();
    tick();
    nrst = 1;
  endtask

  task automatic run_stream(input int n, input int pin, input int pout,
                            input bit rnd, input int base, input int budget);
    int sent, cyc;
    bit fire;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < budget) begin
      in_valid  = ($urandom_range(99) < pin);
      in_data   = rnd ? $urandom : 32'(base + sent);
      out_ready = ($urandom_range(99) < pout);
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
      cyc++;
    end
    in_valid = 0;
    if (sent < n) chk("stream_timeout", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    int cyc;
    in_valid = 0;
    out_ready = 1;
    cyc = 0;
    while ((exp_q.size() > 0 || out_valid) && cyc < 4 * N) begin
      tick();
      cyc++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int sent, cyc, drops, gaps, hold_bad, out0, f0;
    bit fire, started;

    // reset state
    nrst = 0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flags", {62'd0, out_first, out_last}, 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    nrst = 1;

    // one frame, data = index, check latency
    out_ready = 1;
    for (int k = 0; k < N; k++) begin
      in_valid = 1;
      in_data = 32'(k);
      tick();
    end
    in_valid = 0;
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_pos0", {31'd0, out_first, out_data}, {31'd0, 1'b1, 32'd0});
    drain();

    // four back-to-back frames
    do_reset();
    out_ready = 1;
    sent = 0; drops = 0; gaps = 0; started = 0;
    out0 = n_out;
    for (cyc = 0; cyc < 4 * N + 3 * N; cyc++) begin
      in_valid = (sent < 4 * N);
      in_data  = 32'(sent);
      if (!in_ready) drops++;
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
      if (out_valid) started = 1;
      if (started && (n_out - out0) < 4 * N && !out_valid) gaps++;
    end
    in_valid = 0;
    chk("stream_in_ready_drops", 64'(drops), 64'd0);
    chk("stream_out_gaps", 64'(gaps), 64'd0);
    chk("stream_out_count", 64'(n_out - out0), 64'(4 * N));
    drain();

    // sustained stall fills both banks
    do_reset();
    out_ready = 0;
    sent = 0; hold_bad = 0;
    for (cyc = 0; cyc < 300 && sent < 200; cyc++) begin
      in_valid = 1;
      in_data  = 32'(sent);
      fire = in_ready;
      tick();
      if (fire) sent++;
      if (out_valid && out_data != 0) hold_bad++;
    end
    in_valid = 0;
    chk("stall_accepted", 64'(sent), 64'(2 * N));
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_hold", 64'(hold_bad), 64'd0);
    out_ready = 1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!in_ready && cyc < 200);
    chk("stall_release_edges", 64'(cyc), 64'(N - 1));
    run_stream(72, 100, 100, 0, 128, 400);
    drain();

    // random valid/ready over 20 frames
    do_reset();
    f0 = n_first;
    run_stream(20 * N, 50, 50, 1, 0, 20 * N * 10);
    drain();
    chk("rand_frame_firsts", 64'(n_first - f0), 64'd20);

    // partial frame discarded by reset
    do_reset();
    out_ready = 1;
    run_stream(40, 100, 100, 0, 500, 100);
    do_reset();
    chk("partial_no_out", 64'(out_valid), 64'd0);
    run_stream(N, 100, 100, 0, 100, 200);
    drain();

    // reset mid-drain
    do_reset();
    run_stream(N, 100, 100, 0, 300, 200);
    out_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("middrain_valid", 64'(out_valid), 64'd1);
    nrst = 0;
    tick();
    chk("middrain_rst_valid", 64'(out_valid), 64'd0);
    chk("middrain_rst_ready", 64'(in_ready), 64'd1);
    nrst = 1;
    run_stream(N, 100, 100, 0, 400, 200);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
